// File: rtl/frontend_cmd_queue.sv
// Command/write-data FIFO between the host frontend and the backend controller.
// First-word-fall-through head; read issue is throttled by the reads-in-flight limit.
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 32
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif

module frontend_cmd_queue #(
  parameter int unsigned CMD_W      = `FRONTEND_CMD_BITS,
  parameter int unsigned DATA_W     = `DQ_BITS*8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_RD_OUT = 4,
  parameter int unsigned OP_LSB     = 0,
  parameter int unsigned OP_W       = 2,
  parameter logic [OP_W-1:0] OP_READ = 2'd1
) (
  input  logic                               clk,
  input  logic                               power_on_rst,
  input  logic                               i_cmd_valid,
  output logic                               o_cmd_ready,
  input  logic [CMD_W-1:0]                   i_cmd,
  input  logic [DATA_W-1:0]                  i_wdata,
  output logic                               o_backend_cmd_valid,
  input  logic                               i_backend_ready,
  output logic [CMD_W-1:0]                   o_backend_cmd,
  output logic [DATA_W-1:0]                  o_backend_wdata,
  input  logic                               i_backend_read_data_valid,
  output logic [$clog2(DEPTH):0]             o_count,
  output logic [$clog2(MAX_RD_OUT):0]        o_rd_outstanding,
  output logic                               o_rd_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = $clog2(MAX_RD_OUT) + 1;

  logic [CMD_W-1:0]  cmd_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [RW-1:0] rd_out;
  logic          underflow;

  logic [CMD_W-1:0] head_cmd;
  logic             head_is_read;
  logic             rd_full;
  logic             push;
  logic             pop;
  logic             pop_read;

  always_comb begin
    head_cmd            = cmd_mem[rd_ptr];
    head_is_read        = (head_cmd[OP_LSB +: OP_W] == OP_READ);
    rd_full             = (rd_out == RW'(MAX_RD_OUT));
    o_cmd_ready         = (count < CW'(DEPTH));
    // Only reads are held back by the in-flight limit; writes go whenever the backend is ready.
    o_backend_cmd_valid = (count != '0) && !(head_is_read && rd_full);
    o_backend_cmd       = head_cmd;
    o_backend_wdata     = data_mem[rd_ptr];
    push                = i_cmd_valid && o_cmd_ready;
    pop                 = o_backend_cmd_valid && i_backend_ready;
    pop_read            = pop && head_is_read;
    o_count             = count;
    o_rd_outstanding    = rd_out;
    o_rd_underflow      = underflow;
  end

  always_ff @(posedge clk) begin
    if (push && !power_on_rst) begin
      cmd_mem[wr_ptr]  <= i_cmd;
      data_mem[wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      rd_out    <= '0;
      underflow <= 1'b0;
    end else begin
      case ({pop_read, i_backend_read_data_valid})
        2'b10: rd_out <= rd_out + RW'(1);
        2'b01: begin
          // A return with nothing in flight is an error: hold at zero and flag it.
          if (rd_out == '0) underflow <= 1'b1;
          else              rd_out    <= rd_out - RW'(1);
        end
        default: rd_out <= rd_out;
      endcase
    end
  end

endmodule

// File: tb/tb_frontend_cmd_queue.sv
// Bench for frontend_cmd_queue: directed scenarios plus random traffic, all
// checked each cycle against a queue-based reference model.
module tb_frontend_cmd_queue;

  localparam int unsigned CMD_W  = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned MAXRD  = 4;
  localparam logic [1:0]  OPRD   = 2'd1;
  localparam logic [1:0]  OPWR   = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] wdata;
  logic              be_valid;
  logic              be_ready;
  logic [CMD_W-1:0]  be_cmd;
  logic [DATA_W-1:0] be_wdata;
  logic              rd_ret;
  logic [3:0]        count;
  logic [2:0]        rd_outstanding;
  logic              rd_underflow;

  always #5 clk = ~clk;

  frontend_cmd_queue #(
    .CMD_W(CMD_W),
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .MAX_RD_OUT(MAXRD)
  ) dut (
    .clk(clk),
    .power_on_rst(rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd(cmd),
    .i_wdata(wdata),
    .o_backend_cmd_valid(be_valid),
    .i_backend_ready(be_ready),
    .o_backend_cmd(be_cmd),
    .o_backend_wdata(be_wdata),
    .i_backend_read_data_valid(rd_ret),
    .o_count(count),
    .o_rd_outstanding(rd_outstanding),
    .o_rd_underflow(rd_underflow)
  );

  typedef struct packed {
    logic [CMD_W-1:0]  c;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t m_q[$];
  int     m_out;
  logic   m_uf;
  int     total = 0;
  int     bad   = 0;
  int     issued;

  function automatic logic [CMD_W-1:0] mk(input logic [1:0] op, input int row, input int col);
    logic [15:0] r;
    logic [13:0] cl;
    r  = 16'(row);
    cl = 14'(col);
    return {r, cl, op};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_head_read();
    logic [CMD_W-1:0] h;
    if (m_q.size() == 0) return 1'b0;
    h = m_q[0].c;
    return h[1:0] == OPRD;
  endfunction

  function automatic logic m_valid();
    return (m_q.size() != 0) && !(m_head_read() && m_out == MAXRD);
  endfunction

  // One clock: drive at negedge, check outputs mid-low-phase, advance model at posedge.
  task automatic cyc(input logic cv, input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] d,
                     input logic br, input logic rv, input logic r);
    logic push, pop, hr;
    cmd_valid = cv; cmd = c; wdata = d; be_ready = br; rd_ret = rv; rst = r;
    #1;
    check("count", 128'(count), 128'(m_q.size()));
    check("cmd_ready", 128'(cmd_ready), 128'(m_q.size() < DEPTH));
    check("be_valid", 128'(be_valid), 128'(m_valid()));
    check("rd_outstanding", 128'(rd_outstanding), 128'(m_out));
    check("rd_underflow", 128'(rd_underflow), 128'(m_uf));
    if (m_q.size() != 0) begin
      check("head_cmd", 128'(be_cmd), 128'(m_q[0].c));
      check("head_wdata", 128'(be_wdata), 128'(m_q[0].d));
    end
    push = cv && (m_q.size() < DEPTH);
    pop  = m_valid() && br;
    hr   = m_head_read();
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_out = 0;
      m_uf  = 1'b0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        if (hr) issued++;
      end
      if (push) m_q.push_back('{c: c, d: d});
      if (pop && hr && !rv)       m_out++;
      else if (rv && !(pop && hr)) begin
        if (m_out == 0) m_uf = 1'b1;
        else            m_out--;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic br, input logic rv);
    cyc(1'b0, '0, '0, br, rv, 1'b0);
  endtask

  initial begin
    logic [CMD_W-1:0]  rc;
    logic [DATA_W-1:0] rdat;
    m_out = 0; m_uf = 1'b0; issued = 0;
    cmd_valid = 0; cmd = '0; wdata = '0; be_ready = 0; rd_ret = 0; rst = 1;
    @(negedge clk);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, mk(OPRD, 1, 1), '0, 1'b1, 1'b1, 1'b1);

    // Single write push with backend ready
    cyc(1'b1, mk(OPWR, 5, 8), 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b0, 1'b0);
    check("one_write_count", 128'(count), 128'(1));
    idle(1'b1, 1'b0);
    check("one_write_drained", 128'(count), 128'(0));

    // Fill to full; ninth held by host until a slot frees
    for (int i = 0; i < 8; i++) cyc(1'b1, mk(OPWR, i, i), 64'(i) * 64'h1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, mk(OPWR, 9, 9), 64'h9999, 1'b0, 1'b0, 1'b0);
    check("full_count", 128'(count), 128'(8));
    check("full_ready_low", 128'(cmd_ready), 128'(0));
    cyc(1'b1, mk(OPWR, 9, 9), 64'h9999, 1'b1, 1'b0, 1'b0);
    check("ready_after_pop", 128'(cmd_ready), 128'(1));
    cyc(1'b1, mk(OPWR, 9, 9), 64'h9999, 1'b0, 1'b0, 1'b0);
    check("ninth_held", 128'(count), 128'(8));
    for (int i = 0; i < 9; i++) idle(1'b1, 1'b0);

    // Read limit: five reads queued, only four issue without returns
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(OPRD, 20 + i, i), '0, 1'b0, 1'b0, 1'b0);
    issued = 0;
    for (int i = 0; i < 8; i++) idle(1'b1, 1'b0);
    check("reads_issued", 128'(issued), 128'(4));
    check("rd_out_max", 128'(rd_outstanding), 128'(4));
    check("rd_blocked_valid", 128'(be_valid), 128'(0));
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    check("fifth_issued", 128'(issued), 128'(5));
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);
    check("rd_out_drained", 128'(rd_outstanding), 128'(0));

    // Steady state at count 3 with push and pop each cycle
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(OPWR, 100 + i, 0), 64'(100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, mk(OPWR, 200 + i, 1), 64'(200 + i), 1'b1, 1'b0, 1'b0);
    check("steady_count", 128'(count), 128'(3));
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

    // Underflow, then reset mid-burst clears it
    idle(1'b0, 1'b1);
    check("underflow_set", 128'(rd_underflow), 128'(1));
    check("underflow_cnt0", 128'(rd_outstanding), 128'(0));
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(OPRD, i, 3), '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, mk(OPRD, 7, 3), '0, 1'b1, 1'b1, 1'b1);
    check("rst_count", 128'(count), 128'(0));
    check("rst_underflow", 128'(rd_underflow), 128'(0));
    check("rst_valid", 128'(be_valid), 128'(0));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rc   = mk(($urandom_range(0, 1) != 0) ? OPRD : OPWR, int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 16383)));
      rdat = {$urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, rc, rdat, $urandom_range(0, 2) != 0,
          ($urandom_range(0, 3) == 0) && (m_out != 0 || $urandom_range(0, 15) == 0),
          $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frontend_cmd_queue.md
FRONTEND_CMD_QUEUE -- requirements
Module: frontend_cmd_queue

Interface
REQ-001 SHALL have parameter CMD_W, default `FRONTEND_CMD_BITS, width of one frontend_command_t.
REQ-002 SHALL have parameter DATA_W, default `DQ_BITS*8, width of one write burst.
REQ-003 SHALL have parameter DEPTH, default 8, queue entries (power of two, >=2).
REQ-004 SHALL have parameter MAX_RD_OUT, default 4, reads issued to backend but not yet returned.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port power_on_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_cmd_valid  in  1  host command valid.
REQ-008 SHALL have port o_cmd_ready  out  1  queue can accept a command.
REQ-009 SHALL have port i_cmd  in  CMD_W  host command (frontend_command_t).
REQ-010 SHALL have port i_wdata  in  DATA_W  write data paired with i_cmd.
REQ-011 SHALL have port o_backend_cmd_valid  out  1  head command offered to backend controller.
REQ-012 SHALL have port i_backend_ready  in  1  backend controller ready.
REQ-013 SHALL have port o_backend_cmd  out  CMD_W  head command.
REQ-014 SHALL have port o_backend_wdata  out  DATA_W  head write data.
REQ-015 SHALL have port i_backend_read_data_valid  in  1  one read burst returned by backend.
REQ-016 SHALL have port o_count  out  $clog2(DEPTH)+1  entries currently held.
REQ-017 SHALL have port o_rd_outstanding  out  $clog2(MAX_RD_OUT)+1  reads in flight.
REQ-018 SHALL have port o_rd_underflow  out  1  sticky error flag.

Function
REQ-019 SHALL store command and write data together in a circular buffer of DEPTH entries; write and read pointers wrap from DEPTH-1 to 0.
REQ-020 SHALL accept (push) when i_cmd_valid && o_cmd_ready at a rising edge.
REQ-021 SHALL drive o_cmd_ready = (o_count < DEPTH), derived only from registered state and never from i_cmd_valid.
REQ-022 SHALL present the head entry on o_backend_cmd/o_backend_wdata combinationally from storage (first-word-fall-through); a push into an empty queue SHALL be visible on the cycle after the accepting edge.
REQ-023 SHALL define head_is_read = (op_type field of head == OP_READ).
REQ-024 SHALL drive o_backend_cmd_valid = (o_count != 0) && !(head_is_read && o_rd_outstanding == MAX_RD_OUT).
REQ-025 SHALL pop when o_backend_cmd_valid && i_backend_ready at a rising edge; o_backend_cmd and o_backend_wdata SHALL stay stable while valid is high and not yet accepted.
REQ-026 SHALL handle simultaneous push and pop: o_count unchanged, both pointers advance; when full, no push occurs (ready low), and pop alone frees one entry, raising o_cmd_ready on the next cycle.
REQ-027 SHALL update o_rd_outstanding as: +1 on pop of a read; -1 on i_backend_read_data_valid; unchanged when both occur in the same cycle.
REQ-028 SHALL, on i_backend_read_data_valid while o_rd_outstanding == 0 and no read pops that cycle, hold the counter at 0 and set o_rd_underflow until reset.
REQ-029 SHALL not block write commands at the head because of the read limit; write issue is gated only by i_backend_ready.
REQ-030 SHALL preserve command order; no reordering or bypass.

Reset
REQ-031 SHALL, while power_on_rst is high at a rising edge, clear both pointers, o_count=0, o_rd_outstanding=0, o_rd_underflow=0; hence o_cmd_ready=1 and o_backend_cmd_valid=0 after that edge.
REQ-032 SHALL ignore i_cmd_valid and i_backend_read_data_valid in any cycle with power_on_rst high; entries in flight at reset mid-operation are discarded.
REQ-033 SHALL leave storage contents uninitialised; no output depends on them while o_count==0.

Verification
REQ-034 SHALL cover: reset, push one write (row 5, col 8, data 0xA5..), backend ready -> valid next cycle, popped in 1 cycle, o_count 1->0.
REQ-035 SHALL cover: push 8 commands with backend ready=0 -> o_count=8, o_cmd_ready=0; 9th command held by host, not lost; one pop -> ready=1 next cycle.
REQ-036 SHALL cover: 5 reads queued, ready=1, no returns -> exactly 4 issued, o_rd_outstanding=4, valid low; one read_data_valid -> 5th issues next cycle.
REQ-037 SHALL cover: queue at count 3 with push and pop every cycle for 20 cycles -> o_count stays 3, order preserved.
REQ-038 SHALL cover: read_data_valid with o_rd_outstanding=0 -> o_rd_underflow=1 and counter 0; reset asserted mid-burst of pushes -> all counters 0, underflow cleared.
